rv32v_fetch2_stage: RTL and testbench

- Producer end of the fetch2-to-decode interface for the vector-extension pipeline.
- Accepts fetch-response beats from fetch1: instruction word, PC and bus-fault flag.
- Classifies each beat as misaligned, faulted or good, and buffers beats in a small FIFO.
- Presents the head entry to decode as instr / mal_insn / fault_insn, with a valid/ready handshake, flush support and halt-on-fault sequencing.

---
 rtl/rv32v_fetch2_stage.sv | 92 +++++++++
 tb/tb_rv32v_fetch2_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rv32v_fetch2_stage.sv
// Fetch2 stage: classifies fetch1 beats, buffers them in a small FIFO and presents
// the head entry to decode. Halts intake after a faulted/misaligned beat until flush.
module rv32v_fetch2_stage #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        f1_valid,
  input  logic [31:0] f1_instr,
  input  logic [31:0] f1_pc,
  input  logic        f1_fault,
  output logic        f1_ready,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] instr,
  output logic        mal_insn,
  output logic        fault_insn,
  output logic [31:0] dec_pc
);

  // state  | meaning
  // S_RUN  | accepting beats while the FIFO has room
  // S_HALT | a bad beat was accepted; intake closed until flush, decode drains
  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  state_t      r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic          r_mal   [DEPTH];
  logic          r_flt   [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_mal;
  logic w_flt;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_mal   = (f1_pc[1:0] != 2'b00);
  assign w_flt   = f1_fault & ~w_mal;

  // Ready depends only on registered state, so a full FIFO refuses even when decode pops.
  assign f1_ready = (r_state == S_RUN) & ~w_full;
  assign dec_valid = ~w_empty;

  assign w_push = f1_valid & f1_ready & ~flush;
  assign w_pop  = dec_valid & dec_ready & ~flush;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      r_state  <= S_RUN;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= (w_mal || w_flt) ? NOP_INSTR : f1_instr;
        r_pc[r_wr_ptr]    <= f1_pc;
        r_mal[r_wr_ptr]   <= w_mal;
        r_flt[r_wr_ptr]   <= w_flt;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        if (w_mal || w_flt) begin
          r_state <= S_HALT;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign instr      = w_empty ? NOP_INSTR : r_instr[r_rd_ptr];
  assign mal_insn   = w_empty ? 1'b0      : r_mal[r_rd_ptr];
  assign fault_insn = w_empty ? 1'b0      : r_flt[r_rd_ptr];
  assign dec_pc     = w_empty ? 32'h0     : r_pc[r_rd_ptr];

endmodule

// File: tb/tb_rv32v_fetch2_stage.sv
// Bench for rv32v_fetch2_stage: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch2 buffer.
module tb_rv32v_fetch2_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST, flush, f1_valid, f1_fault, dec_ready;
  logic [31:0] f1_instr, f1_pc;
  logic        f1_ready, dec_valid, mal_insn, fault_insn;
  logic [31:0] instr, dec_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mal;
    logic        flt;
  } entry_t;

  entry_t m_q[$];
  bit     m_halt;

  rv32v_fetch2_stage #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .f1_valid(f1_valid), .f1_instr(f1_instr), .f1_pc(f1_pc), .f1_fault(f1_fault),
    .f1_ready(f1_ready), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .instr(instr), .mal_insn(mal_insn), .fault_insn(fault_insn), .dec_pc(dec_pc)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer head.
  task automatic check_outputs(input string tag);
    bit m_ready;
    m_ready = !m_halt && (m_q.size() < DEPTH);
    chk({tag, ".f1_ready"}, 32'(f1_ready), 32'(m_ready));
    chk({tag, ".dec_valid"}, 32'(dec_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk({tag, ".instr"}, instr, m_q[0].instr);
      chk({tag, ".mal"}, 32'(mal_insn), 32'(m_q[0].mal));
      chk({tag, ".fault"}, 32'(fault_insn), 32'(m_q[0].flt));
      chk({tag, ".pc"}, dec_pc, m_q[0].pc);
    end else begin
      chk({tag, ".instr"}, instr, NOP);
      chk({tag, ".mal"}, 32'(mal_insn), 32'd0);
      chk({tag, ".fault"}, 32'(fault_insn), 32'd0);
      chk({tag, ".pc"}, dec_pc, 32'd0);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model across the edge.
  task automatic step(input string tag, input bit v, input logic [31:0] ins,
                      input logic [31:0] pc, input bit flt, input bit dr,
                      input bit fl, input bit rst);
    bit     m_ready, do_push, do_pop;
    entry_t e;
    check_outputs(tag);
    RST = rst; flush = fl; f1_valid = v; f1_instr = ins; f1_pc = pc;
    f1_fault = flt; dec_ready = dr;
    m_ready = !m_halt && (m_q.size() < DEPTH);
    @(posedge CLK);
    if (rst || fl) begin
      m_q.delete();
      m_halt = 0;
    end else begin
      do_pop  = (m_q.size() > 0) && dr;
      do_push = v && m_ready;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc    = pc;
        e.mal   = (pc % 4) != 0;
        e.flt   = flt && !e.mal;
        e.instr = (e.mal || e.flt) ? NOP : ins;
        m_q.push_back(e);
        if (e.mal || e.flt) m_halt = 1;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle(input string tag, input bit dr);
    step(tag, 0, 32'h0, 32'h0, 0, dr, 0, 0);
  endtask

  initial begin
    RST = 1; flush = 0; f1_valid = 0; f1_instr = 0; f1_pc = 0; f1_fault = 0; dec_ready = 0;
    m_halt = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    chk("reset.instr", instr, NOP);
    chk("reset.f1_ready", 32'(f1_ready), 32'd1);

    // 1: single beat passes through with one cycle of latency
    step("t1.push", 1, 32'h00A0_0093, 32'h100, 0, 1, 0, 0);
    chk("t1.instr", instr, 32'h00A0_0093);
    chk("t1.pc", dec_pc, 32'h100);
    idle("t1.pop", 1);
    idle("t1.empty", 1);

    // 2: stall decode, overfill, third beat held until space opens
    step("t2.p0", 1, 32'h1111_1111, 32'h0, 0, 0, 0, 0);
    step("t2.p1", 1, 32'h2222_2222, 32'h4, 0, 0, 0, 0);
    chk("t2.full_ready", 32'(f1_ready), 32'd0);
    step("t2.p2a", 1, 32'h3333_3333, 32'h8, 0, 0, 0, 0);
    step("t2.p2b", 1, 32'h3333_3333, 32'h8, 0, 0, 0, 0);
    chk("t2.stall_instr", instr, 32'h1111_1111);
    step("t2.p2c", 1, 32'h3333_3333, 32'h8, 0, 1, 0, 0);
    step("t2.p2d", 1, 32'h3333_3333, 32'h8, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) idle("t2.drain", 1);

    // 3: misaligned beat halts intake; following good beat never accepted
    step("t3.mal", 1, 32'hDEAD_BEEF, 32'h102, 0, 0, 0, 0);
    chk("t3.mal_flag", 32'(mal_insn), 32'd1);
    chk("t3.nop", instr, NOP);
    step("t3.good", 1, 32'h0000_0093, 32'h104, 0, 0, 0, 0);
    step("t3.good2", 1, 32'h0000_0093, 32'h104, 0, 1, 0, 0);
    step("t3.good3", 1, 32'h0000_0093, 32'h104, 0, 1, 0, 0);
    chk("t3.halt_ready", 32'(f1_ready), 32'd0);
    step("t3.flush", 0, 32'h0, 32'h0, 0, 0, 1, 0);

    // 4: faulted beat, flush, then normal flow resumes
    step("t4.flt", 1, 32'h1234_5678, 32'h200, 1, 0, 0, 0);
    chk("t4.fault_flag", 32'(fault_insn), 32'd1);
    step("t4.flush", 0, 32'h0, 32'h0, 0, 0, 1, 0);
    chk("t4.ready", 32'(f1_ready), 32'd1);
    step("t4.new", 1, 32'h0050_0113, 32'h300, 0, 0, 0, 0);
    chk("t4.new_pc", dec_pc, 32'h300);
    idle("t4.pop", 1);

    // 5: full FIFO flushed while push and pop both requested
    step("t5.p0", 1, 32'hAAAA_0001, 32'h10, 0, 0, 0, 0);
    step("t5.p1", 1, 32'hAAAA_0002, 32'h14, 0, 0, 0, 0);
    step("t5.flush", 1, 32'hAAAA_0003, 32'h18, 0, 1, 1, 0);
    chk("t5.valid", 32'(dec_valid), 32'd0);

    // 6: reset discards buffered entries
    step("t6.p0", 1, 32'hBBBB_0001, 32'h20, 0, 0, 0, 0);
    step("t6.p1", 1, 32'hBBBB_0002, 32'h24, 0, 0, 0, 0);
    step("t6.rst", 1, 32'hBBBB_0003, 32'h28, 0, 1, 0, 1);
    chk("t6.valid", 32'(dec_valid), 32'd0);
    chk("t6.ready", 32'(f1_ready), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 15) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, pc,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 63) == 0);
    end
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
